// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU-control
// decode, 32-bit ALU, branch-target adder and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          RegDst,
  input  logic          ALUSrc,
  input  logic          MemtoReg,
  input  logic          RegWrite,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          Branch,
  input  logic          ALUOp1,
  input  logic          ALUOp0,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] s_extend,
  input  logic [RW-1:0] instr_2521,
  input  logic [RW-1:0] instr_2016,
  input  logic [RW-1:0] instr_1511,
  input  logic          memwb_RegWrite,
  input  logic [RW-1:0] memwb_dest,
  input  logic [DW-1:0] memwb_wdata,
  output logic          MemtoReg_out,
  output logic          RegWrite_out,
  output logic          MemRead_out,
  output logic          MemWrite_out,
  output logic          Branch_out,
  output logic [DW-1:0] branch_target,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] store_data,
  output logic [RW-1:0] dest_out
);

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_NOR,
    OP_SLT,
    OP_NONE
  } alu_op_t;

  // EX/MEM register contents
  logic          mem_to_reg_p1;
  logic          reg_write_p1;
  logic          mem_read_p1;
  logic          mem_write_p1;
  logic          branch_p1;
  logic [DW-1:0] branch_target_p1;
  logic          zero_p1;
  logic [DW-1:0] alu_result_p1;
  logic [DW-1:0] store_data_p1;
  logic [RW-1:0] dest_p1;

  // EX combinational signals
  logic signed [DW-1:0] fwd_a_p0;
  logic signed [DW-1:0] fwd_b_p0;
  logic signed [DW-1:0] alu_b_p0;
  logic        [DW-1:0] alu_res_p0;
  logic        [DW-1:0] branch_target_p0;
  logic        [RW-1:0] dest_p0;
  alu_op_t              alu_op_p0;

  // Selects the freshest copy of a source register: the instruction one ahead
  // (still sitting in EX/MEM) beats the one in MEM/WB; $zero never forwards.
  function automatic logic [DW-1:0] forward_sel(
    input logic [RW-1:0] src,
    input logic [DW-1:0] reg_val,
    input logic          ex_wr,
    input logic [RW-1:0] ex_dest,
    input logic [DW-1:0] ex_val,
    input logic          wb_wr,
    input logic [RW-1:0] wb_dest,
    input logic [DW-1:0] wb_val
  );
    if (ex_wr && (ex_dest != '0) && (ex_dest == src))
      return ex_val;
    else if (wb_wr && (wb_dest != '0) && (wb_dest == src))
      return wb_val;
    else
      return reg_val;
  endfunction

  // Add/sub wrap modulo 2^DW; slt is a signed compare zero-extended to DW.
  function automatic logic [DW-1:0] alu_calc(
    input alu_op_t              op,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return {{(DW-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  // Operand forwarding from the registered EX/MEM slot and from MEM/WB
  always_comb begin
    fwd_a_p0 = forward_sel(instr_2521, rdata1, reg_write_p1, dest_p1, alu_result_p1,
                           memwb_RegWrite, memwb_dest, memwb_wdata);
    fwd_b_p0 = forward_sel(instr_2016, rdata2, reg_write_p1, dest_p1, alu_result_p1,
                           memwb_RegWrite, memwb_dest, memwb_wdata);
    alu_b_p0 = ALUSrc ? s_extend : fwd_b_p0;
  end

  // ALU-control decode: ALUOp selects add/sub directly or defers to funct
  always_comb begin
    alu_op_p0 = OP_NONE;
    case ({ALUOp1, ALUOp0})
      2'b00, 2'b11: alu_op_p0 = OP_ADD;
      2'b01:        alu_op_p0 = OP_SUB;
      default: begin
        case (s_extend[5:0])
          6'b100000: alu_op_p0 = OP_ADD;
          6'b100010: alu_op_p0 = OP_SUB;
          6'b100100: alu_op_p0 = OP_AND;
          6'b100101: alu_op_p0 = OP_OR;
          6'b100111: alu_op_p0 = OP_NOR;
          6'b101010: alu_op_p0 = OP_SLT;
          default:   alu_op_p0 = OP_NONE;
        endcase
      end
    endcase
  end

  // ALU, branch-target adder and destination select
  always_comb begin
    alu_res_p0       = alu_calc(alu_op_p0, fwd_a_p0, alu_b_p0);
    branch_target_p0 = npc + (s_extend << 2);
    dest_p0          = RegDst ? instr_1511 : instr_2016;
  end

  // ---- EX -> EX/MEM boundary ----
  // EX/MEM register: reset clears, flush bubbles control only, stall holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_to_reg_p1    <= 1'b0;
      reg_write_p1     <= 1'b0;
      mem_read_p1      <= 1'b0;
      mem_write_p1     <= 1'b0;
      branch_p1        <= 1'b0;
      branch_target_p1 <= '0;
      zero_p1          <= 1'b0;
      alu_result_p1    <= '0;
      store_data_p1    <= '0;
      dest_p1          <= '0;
    end else if (flush || !stall) begin
      mem_to_reg_p1    <= flush ? 1'b0 : MemtoReg;
      reg_write_p1     <= flush ? 1'b0 : RegWrite;
      mem_read_p1      <= flush ? 1'b0 : MemRead;
      mem_write_p1     <= flush ? 1'b0 : MemWrite;
      branch_p1        <= flush ? 1'b0 : Branch;
      branch_target_p1 <= branch_target_p0;
      zero_p1          <= (alu_res_p0 == '0);
      alu_result_p1    <= alu_res_p0;
      store_data_p1    <= fwd_b_p0;
      dest_p1          <= dest_p0;
    end
  end

  assign MemtoReg_out  = mem_to_reg_p1;
  assign RegWrite_out  = reg_write_p1;
  assign MemRead_out   = mem_read_p1;
  assign MemWrite_out  = mem_write_p1;
  assign Branch_out    = branch_p1;
  assign branch_target = branch_target_p1;
  assign zero          = zero_p1;
  assign alu_result    = alu_result_p1;
  assign store_data    = store_data_p1;
  assign dest_out      = dest_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0;
  logic [31:0] npc, rdata1, rdata2, s_extend, memwb_wdata;
  logic [4:0]  instr_2521, instr_2016, instr_1511, memwb_dest;
  logic        memwb_RegWrite;
  logic        MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, zero;
  logic [31:0] branch_target, alu_result, store_data;
  logic [4:0]  dest_out;

  typedef struct {
    logic        mtr, rw, mr, mw, br;
    logic [31:0] bt;
    logic        zr;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dest;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  execute_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0),
    .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .instr_2521(instr_2521), .instr_2016(instr_2016), .instr_1511(instr_1511),
    .memwb_RegWrite(memwb_RegWrite), .memwb_dest(memwb_dest), .memwb_wdata(memwb_wdata),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .Branch_out(Branch_out), .branch_target(branch_target),
    .zero(zero), .alu_result(alu_result), .store_data(store_data), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z.mtr = 0; z.rw = 0; z.mr = 0; z.mw = 0; z.br = 0;
    z.bt = 0; z.zr = 0; z.alu = 0; z.sd = 0; z.dest = 0;
    return z;
  endfunction

  // Reference model of one EX evaluation against the model's EX/MEM state
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] base);
    if (m.rw && m.dest != 0 && m.dest == src) return m.alu;
    if (memwb_RegWrite && memwb_dest != 0 && memwb_dest == src) return memwb_wdata;
    return base;
  endfunction

  function automatic exp_t model_next();
    exp_t n;
    logic [31:0] a, b, bin, res;
    a   = fwd(instr_2521, rdata1);
    b   = fwd(instr_2016, rdata2);
    bin = ALUSrc ? s_extend : b;
    case ({ALUOp1, ALUOp0})
      2'b00, 2'b11: res = a + bin;
      2'b01:        res = a - bin;
      default: case (s_extend[5:0])
        6'h20:   res = a + bin;
        6'h22:   res = a - bin;
        6'h24:   res = a & bin;
        6'h25:   res = a | bin;
        6'h27:   res = ~(a | bin);
        6'h2a:   res = ($signed(a) < $signed(bin)) ? 32'd1 : 32'd0;
        default: res = 32'd0;
      endcase
    endcase
    n.mtr = MemtoReg; n.rw = RegWrite; n.mr = MemRead; n.mw = MemWrite; n.br = Branch;
    n.bt = npc + (s_extend << 2);
    n.zr = (res == 0);
    n.alu = res;
    n.sd = b;
    n.dest = RegDst ? instr_1511 : instr_2016;
    if (flush) begin
      n.mtr = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0;
    end else if (stall) begin
      n = m;
    end
    return n;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".MemtoReg"}, {31'd0, MemtoReg_out}, {31'd0, e.mtr});
    chk({tag, ".RegWrite"}, {31'd0, RegWrite_out}, {31'd0, e.rw});
    chk({tag, ".MemRead"},  {31'd0, MemRead_out},  {31'd0, e.mr});
    chk({tag, ".MemWrite"}, {31'd0, MemWrite_out}, {31'd0, e.mw});
    chk({tag, ".Branch"},   {31'd0, Branch_out},   {31'd0, e.br});
    chk({tag, ".btarget"},  branch_target, e.bt);
    chk({tag, ".zero"},     {31'd0, zero}, {31'd0, e.zr});
    chk({tag, ".alu"},      alu_result, e.alu);
    chk({tag, ".store"},    store_data, e.sd);
    chk({tag, ".dest"},     {27'd0, dest_out}, {27'd0, e.dest});
  endtask

  // Push expectation, clock once, pop and compare
  task automatic step(input string tag);
    exp_t e;
    m = model_next();
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  // ctrl = {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp1,ALUOp0}
  task automatic set_in(input logic [8:0] ctrl, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] se, input logic [31:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0} = ctrl;
    rdata1 = r1; rdata2 = r2; s_extend = se; npc = pc;
    instr_2521 = rs; instr_2016 = rt; instr_1511 = rd;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] d, input logic [31:0] v);
    memwb_RegWrite = we; memwb_dest = d; memwb_wdata = v;
  endtask

  localparam logic [8:0] C_RADD  = 9'b1_0_0_1_0_0_0_1_0;
  localparam logic [8:0] C_RNOWR = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] C_BEQ   = 9'b0_0_0_0_0_0_1_0_1;
  localparam logic [8:0] C_LW    = 9'b0_1_1_1_1_0_0_0_0;
  localparam logic [8:0] C_SW    = 9'b0_1_0_0_0_1_0_0_0;
  localparam logic [8:0] C_OP11  = 9'b0_1_0_1_0_0_0_1_1;

  initial begin
    rst = 1'b1; stall = 0; flush = 0;
    set_in(9'd0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    m = zero_state();
    #12;
    check_outputs("reset", zero_state());
    @(negedge clk);
    rst = 1'b0;

    // 1: R-type add 5+7 -> rd 3
    set_in(C_RADD, 5, 7, 32'h20, 32'h40, 5'd1, 5'd2, 5'd3);
    step("radd");
    chk("radd.const_alu", alu_result, 32'd12);

    // 2: beq-style subtract of equal operands
    set_in(C_BEQ, 32'h1234, 32'h1234, 32'd4, 32'h100, 5'd6, 5'd7, 5'd0);
    step("beq");
    chk("beq.const_bt", branch_target, 32'h110);

    // 3: forwarding priority
    set_in(C_RADD, 5, 7, 32'h20, 0, 5'd8, 5'd9, 5'd2);
    set_wb(1, 5'd2, 32'd99);
    step("fwd.prod");
    set_in(C_RADD, 0, 2, 32'h22, 0, 5'd2, 5'd0, 5'd4);
    step("fwd.ex");
    chk("fwd.ex.const", alu_result, 32'd10);
    set_in(C_RNOWR, 5, 7, 32'h20, 0, 5'd8, 5'd9, 5'd2);
    step("fwd.nowr.prod");
    set_in(C_RADD, 0, 2, 32'h22, 0, 5'd2, 5'd0, 5'd4);
    step("fwd.mem");
    chk("fwd.mem.const", alu_result, 32'd97);
    set_wb(1, 5'd0, 32'd99);
    set_in(C_RADD, 5, 7, 32'h20, 0, 5'd8, 5'd9, 5'd0);
    step("fwd.zero.prod");
    set_in(C_RADD, 50, 2, 32'h22, 0, 5'd0, 5'd0, 5'd4);
    step("fwd.zero");
    chk("fwd.zero.const", alu_result, 32'd48);
    // rt forwarding into store data while ALUSrc picks the immediate
    set_wb(1, 5'd4, 32'd77);
    set_in(C_SW, 32'h200, 32'd1, 32'd8, 0, 5'd10, 5'd4, 5'd0);
    step("fwd.store");
    set_wb(0, 5'd0, 32'd0);

    // 4: slt signed, lw address, other functs, ALUOp 11
    set_in(C_RADD, 32'hFFFF_FFFF, 32'd1, 32'h2a, 0, 5'd11, 5'd12, 5'd13);
    step("slt");
    chk("slt.const", alu_result, 32'd1);
    set_in(C_LW, 32'h1000, 32'd3, 32'hFFFF_FFFC, 32'h80, 5'd14, 5'd15, 5'd0);
    step("lw");
    chk("lw.const", alu_result, 32'hFFC);
    set_in(C_RADD, 32'hF0F0, 32'hFF00, 32'h24, 0, 5'd11, 5'd12, 5'd13);
    step("and");
    set_in(C_RADD, 32'hF0F0, 32'hFF00, 32'h25, 0, 5'd11, 5'd12, 5'd13);
    step("or");
    set_in(C_RADD, 32'hF0F0, 32'hFF00, 32'h27, 0, 5'd11, 5'd12, 5'd13);
    step("nor");
    set_in(C_RADD, 32'hF0F0, 32'hFF00, 32'h3f, 0, 5'd11, 5'd12, 5'd13);
    step("badfunct");
    set_in(C_OP11, 32'hFFFF_FFFF, 0, 32'd1, 32'hFFFF_FFFC, 5'd11, 5'd12, 5'd13);
    step("op11.wrap");
    for (int i = 0; i < 4; i++) begin
      set_in(C_RADD, $urandom, $urandom, (i % 2) ? 32'h2a : 32'h22, $urandom,
             5'(i + 16), 5'(i + 20), 5'(i + 24));
      step("rand");
    end

    // 5: stall holds, flush beats stall
    set_in(C_LW, 32'h2000, 0, 32'd16, 32'h300, 5'd17, 5'd18, 5'd0);
    step("prestall");
    stall = 1;
    set_in(C_RADD, 1, 2, 32'h20, 32'h10, 5'd1, 5'd2, 5'd5);
    step("stall1");
    set_in(C_BEQ, 9, 9, 32'd3, 32'h20, 5'd3, 5'd4, 5'd6);
    step("stall2");
    chk("stall.const_alu", alu_result, 32'h2010);
    flush = 1;
    set_in(C_LW, 32'h40, 0, 32'd4, 32'h50, 5'd19, 5'd20, 5'd0);
    step("flushstall");
    chk("flushstall.const_mr", {31'd0, MemRead_out}, 32'd0);
    chk("flushstall.const_alu", alu_result, 32'h44);
    flush = 0; stall = 0;

    // 6: asynchronous reset mid-cycle
    set_in(C_LW, 32'h500, 0, 32'd4, 32'h60, 5'd21, 5'd22, 5'd0);
    step("prerst");
    @(negedge clk);
    rst = 1;
    #1;
    m = zero_state();
    check_outputs("asyncrst", m);
    @(posedge clk);
    #1;
    check_outputs("rsthold", m);
    @(negedge clk);
    rst = 0;
    set_in(C_RADD, 3, 4, 32'h20, 32'h70, 5'd0, 5'd0, 5'd7);
    step("postrst");
    chk("postrst.const_alu", alu_result, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline; consumes the ID/EX register outputs.
- Contains a forwarding unit, ALU-control decode, a 32-bit ALU and a branch-target adder.
- Results are captured in the EX/MEM pipeline register, which this block owns.
- Outputs feed the MEM stage and are fed back internally for EX-to-EX forwarding.

Parameters:
- DW, 32, datapath width (npc, operands, results).
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  hold EX/MEM contents this cycle
- flush  in  1  squash the instruction entering EX/MEM (branch taken / exception)
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0  in  1 each  ID/EX control
- npc  in  DW  ID/EX PC+4
- rdata1, rdata2  in  DW  ID/EX register-file read data
- s_extend  in  DW  ID/EX sign-extended immediate
- instr_2521, instr_2016, instr_1511  in  RW each  ID/EX rs, rt, rd
- memwb_RegWrite  in  1  MEM/WB write enable
- memwb_dest  in  RW  MEM/WB destination
- memwb_wdata  in  DW  MEM/WB write-back data
- MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out  out  1 each  EX/MEM control
- branch_target  out  DW  EX/MEM branch target
- zero  out  1  EX/MEM ALU-result-is-zero flag
- alu_result  out  DW  EX/MEM ALU result
- store_data  out  DW  EX/MEM forwarded rt data for stores
- dest_out  out  RW  EX/MEM destination register

Behaviour:
- Reset: every output is 0 immediately on rst assertion and stays 0 while rst is high.
- Latency: 1 cycle. Combinational EX logic is registered on posedge clk.
- Forwarding, operand A (rs = instr_2521):
  - EX hazard: RegWrite_out=1, dest_out!=0 and dest_out==rs -> alu_result.
  - Else MEM hazard: memwb_RegWrite=1, memwb_dest!=0 and memwb_dest==rs -> memwb_wdata.
  - Else -> rdata1.
  - EX hazard has priority over MEM hazard.
- Forwarding, rt operand (instr_2016): same rules, base value rdata2. The result is fwdB.
- ALU B input = ALUSrc ? s_extend : fwdB.
- store_data = fwdB, captured regardless of ALUSrc.
- ALU op by {ALUOp1,ALUOp0}:
  - 00 -> add; 01 -> sub; 11 -> add.
  - 10 -> R-type, decoded from funct = s_extend[5:0]: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt.
  - 10 with any other funct -> result 0.
- Arithmetic rules:
  - add/sub are modulo 2^DW; no overflow trap.
  - slt is a signed compare, result 1 or 0 zero-extended.
  - zero = (ALU result == 0), computed on the pre-register value.
- branch_target = npc + (s_extend << 2), modulo 2^DW.
- dest_out = RegDst ? instr_1511 : instr_2016.
- Register update priority per posedge: rst > flush > stall > normal load.
  - flush=1: the five control outputs load 0. Data outputs load normally. flush wins over a simultaneous stall.
  - stall=1 (flush=0): all outputs hold their previous values.
  - Normal: all outputs load the computed values.
- Forwarding uses the current registered EX/MEM values, including values held by stall.
- A flushed slot has RegWrite_out=0, so it never forwards.
- dest_out=0 never forwards (writes to $zero are ignored).
- rst asserted mid-stream clears EX/MEM asynchronously. The first posedge after rst deasserts loads the current inputs.

Test Plan:
1. R-type add, rdata1=5, rdata2=7, ALUOp=10, funct=100000, RegDst=1, rd=3, no hazards -> next cycle alu_result=12, dest_out=3, zero=0, RegWrite_out=1.
2. beq-style op, ALUOp=01, rdata1=rdata2=0x1234, npc=0x100, s_extend=4 -> zero=1, branch_target=0x110, Branch_out=1.
3. Back-to-back dependency:
   - Cycle 1: add to rd=2 yielding 12; same cycle memwb_dest=2 with memwb_wdata=99.
   - Cycle 2: sub with rs=2 -> uses 12 (EX priority).
   - With RegWrite_out=0 instead -> uses 99.
   - With dest_out=0 -> neither forwards.
4. slt with rdata1=0xFFFFFFFF, rdata2=1 -> alu_result=1. lw with ALUSrc=1, rdata1=0x1000, s_extend=0xFFFFFFFC -> alu_result=0xFFC, MemRead_out=1.
5. stall=1 for 2 cycles with changing inputs -> outputs frozen. flush+stall together -> control outputs 0, data outputs updated.
6. Assert rst between clock edges while outputs are non-zero -> all outputs 0 before the next posedge. Deassert -> the first edge loads the current inputs.
